// File: rtl/spi_wb_pkg.sv
// Shared definitions for the spiwishbone command frame: opcodes, header size, FSM and frame-phase types.
package spi_wb_pkg;

    localparam logic [7:0]  CMD_READ  = 8'hA1;
    localparam logic [7:0]  CMD_WRITE = 8'hA2;
    localparam int unsigned HDR_BYTES = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_NEXT,
        ST_WAIT_WR,
        ST_HOLD
    } state_t;

    typedef enum logic [1:0] {
        PH_HDR,
        PH_PAD,
        PH_DATA
    } phase_t;

    // Header byte by index: cmd, address MSB..LSB, length MSB..LSB.
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic wr,
                                            input logic [31:0] addr, input logic [15:0] len);
        logic [7:0] b;
        case (idx)
            3'd0:    b = wr ? CMD_WRITE : CMD_READ;
            3'd1:    b = addr[31:24];
            3'd2:    b = addr[23:16];
            3'd3:    b = addr[15:8];
            3'd4:    b = addr[7:0];
            3'd5:    b = len[15:8];
            3'd6:    b = len[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// SCLK divider plus MOSI/MISO shift pair for one SPI byte (SCLK idles high, MOSI on fall, MISO on rise).
module spi_byte_shifter #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic       i_go,
    input  logic [7:0] i_tx_byte,
    input  logic       i_miso,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_byte_done,
    output logic       o_rx_done,
    output logic [7:0] o_rx_byte
);
    localparam int unsigned DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);

    logic          r_sclk;
    logic          r_active;
    logic [DW-1:0] r_div;
    logic [2:0]    r_bit;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic          w_div_wrap;

    assign w_div_wrap = (r_div == DIV_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sclk   <= 1'b1;
            r_active <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
        end else begin
            if (i_load)
                r_tx <= i_tx_byte;
            if (i_go) begin
                r_sclk   <= 1'b0;
                r_active <= 1'b1;
                r_div    <= '0;
                r_bit    <= '0;
            end else if (r_active) begin
                if (!w_div_wrap) begin
                    r_div <= r_div + 1'b1;
                end else begin
                    r_div <= '0;
                    if (!r_sclk) begin
                        r_sclk <= 1'b1;
                        r_rx   <= {r_rx[6:0], i_miso};
                    end else if (r_bit != 3'd7) begin
                        r_sclk <= 1'b0;
                        r_bit  <= r_bit + 1'b1;
                        r_tx   <= {r_tx[6:0], 1'b0};
                    end else begin
                        r_active <= 1'b0;
                    end
                end
            end
        end
    end

    // Byte end is flagged one cycle early so the next byte can start on time.
    assign o_byte_done = r_active & r_sclk & (r_bit == 3'd7) & (r_div == DIV_PRE);
    assign o_rx_done   = r_active & ~r_sclk & (r_bit == 3'd7) & w_div_wrap;
    assign o_rx_byte   = {r_rx[6:0], i_miso};
    assign o_sclk      = r_sclk;
    assign o_mosi      = r_tx[7];

endmodule

// File: rtl/spi_wb_cmd_master.sv
// SPI master issuing spiwishbone command frames: header, pad and payload sequencing with write-stream handshake.
module spi_wb_cmd_master
    import spi_wb_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned PAD_BYTES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_write,
    input  logic [31:0] i_addr,
    input  logic [15:0] i_len,
    output logic        o_busy,
    output logic        o_done,
    input  logic [7:0]  i_wr_data,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    output logic [7:0]  o_rd_data,
    output logic        o_rd_valid,
    output logic        o_spi_clk,
    output logic        o_spi_mosi,
    output logic        o_spi_cs_n,
    input  logic        i_spi_miso
);
    localparam int unsigned   DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [2:0]    HDR_LAST = 3'(HDR_BYTES - 1);

    state_t        r_state, w_next;
    phase_t        r_phase, w_phase_nxt;
    logic          r_write;
    logic [31:0]   r_addr;
    logic [15:0]   r_len;
    logic [2:0]    r_hdr_idx;
    logic [15:0]   r_pay_cnt;
    logic [7:0]    r_pad_cnt;
    logic [DW-1:0] r_wait;
    logic          r_busy, r_done, r_cs_n, r_rd_valid;
    logic [7:0]    r_rd_data;

    logic       w_start, w_load, w_go, w_pop, w_hdr_adv, w_pad_dec, w_pay_dec;
    logic [7:0] w_tx;
    logic       w_byte_done, w_rx_done, w_rd_take;
    logic [7:0] w_rx_byte;

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (w_load),
        .i_go        (w_go),
        .i_tx_byte   (w_tx),
        .i_miso      (i_spi_miso),
        .o_sclk      (o_spi_clk),
        .o_mosi      (o_spi_mosi),
        .o_byte_done (w_byte_done),
        .o_rx_done   (w_rx_done),
        .o_rx_byte   (w_rx_byte)
    );

    always_comb begin
        w_next      = r_state;
        w_phase_nxt = r_phase;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_go        = 1'b0;
        w_pop       = 1'b0;
        w_hdr_adv   = 1'b0;
        w_pad_dec   = 1'b0;
        w_pay_dec   = 1'b0;
        w_tx        = 8'h00;
        case (r_state)
            ST_IDLE: if (i_start) begin
                w_start     = 1'b1;
                w_load      = 1'b1;
                w_tx        = hdr_byte(3'd0, i_write, i_addr, i_len);
                w_phase_nxt = PH_HDR;
                w_next      = ST_SETUP;
            end
            ST_SETUP: if (r_wait == DIV_LAST) begin
                w_go   = 1'b1;
                w_next = ST_SHIFT;
            end
            ST_SHIFT: if (w_byte_done) w_next = ST_NEXT;
            ST_NEXT: begin
                w_next = ST_SHIFT;
                w_load = 1'b1;
                w_go   = 1'b1;
                if (r_hdr_idx != HDR_LAST) begin
                    w_hdr_adv = 1'b1;
                    w_tx      = hdr_byte(r_hdr_idx + 3'd1, r_write, r_addr, r_len);
                // Reads put pads before payload (turnaround); writes put them after (trailer).
                end else if (r_write && r_pay_cnt != 16'd0) begin
                    if (i_wr_valid) begin
                        w_pop       = 1'b1;
                        w_pay_dec   = 1'b1;
                        w_tx        = i_wr_data;
                        w_phase_nxt = PH_DATA;
                    end else begin
                        w_load = 1'b0;
                        w_go   = 1'b0;
                        w_next = ST_WAIT_WR;
                    end
                end else if (r_pad_cnt != 8'd0) begin
                    w_pad_dec   = 1'b1;
                    w_phase_nxt = PH_PAD;
                end else if (!r_write && r_pay_cnt != 16'd0) begin
                    w_pay_dec   = 1'b1;
                    w_phase_nxt = PH_DATA;
                end else begin
                    w_load = 1'b0;
                    w_go   = 1'b0;
                    w_next = ST_HOLD;
                end
            end
            ST_WAIT_WR: if (i_wr_valid) begin
                w_pop       = 1'b1;
                w_pay_dec   = 1'b1;
                w_load      = 1'b1;
                w_go        = 1'b1;
                w_tx        = i_wr_data;
                w_phase_nxt = PH_DATA;
                w_next      = ST_SHIFT;
            end
            ST_HOLD: if (r_wait == DIV_LAST) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_rd_take = w_rx_done & ~r_write & (r_phase == PH_DATA);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_phase    <= PH_HDR;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_hdr_idx  <= '0;
            r_pay_cnt  <= '0;
            r_pad_cnt  <= '0;
            r_wait     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_state <= w_next;
            r_phase <= w_phase_nxt;
            r_wait  <= (w_next != r_state) ? '0 : r_wait + 1'b1;
            if (w_start) begin
                r_write   <= i_write;
                r_addr    <= i_addr;
                r_len     <= i_len;
                r_hdr_idx <= '0;
                r_pay_cnt <= i_len;
                r_pad_cnt <= 8'(PAD_BYTES);
            end
            if (w_hdr_adv) r_hdr_idx <= r_hdr_idx + 3'd1;
            if (w_pad_dec) r_pad_cnt <= r_pad_cnt - 1'b1;
            if (w_pay_dec) r_pay_cnt <= r_pay_cnt - 1'b1;
            r_busy     <= (w_next != ST_IDLE);
            r_cs_n     <= (w_next == ST_IDLE);
            r_done     <= (r_state == ST_HOLD) && (w_next == ST_IDLE);
            r_rd_valid <= w_rd_take;
            if (w_rd_take) r_rd_data <= w_rx_byte;
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_wr_ready = w_pop & ~i_reset;
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_spi_cs_n = r_cs_n;

endmodule

// File: tb/tb_spi_wb_cmd_master.sv
// Directed bench for spi_wb_cmd_master with an SPI-slave model and SCLK timing monitor.
module tb_spi_wb_cmd_master;
    localparam int unsigned TB_DIV = 4;
    localparam int unsigned TB_PAD = 2;

    logic        i_clk = 1'b0;
    logic        i_reset, i_start, i_write, i_wr_valid;
    logic [31:0] i_addr;
    logic [15:0] i_len;
    logic [7:0]  i_wr_data;
    logic        i_spi_miso = 1'b0;
    logic        o_busy, o_done, o_wr_ready, o_rd_valid, o_spi_clk, o_spi_mosi, o_spi_cs_n;
    logic [7:0]  o_rd_data;

    int vectors = 0;
    int miscompares = 0;

    spi_wb_cmd_master #(.CLK_DIV(TB_DIV), .PAD_BYTES(TB_PAD)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_write(i_write),
        .i_addr(i_addr), .i_len(i_len), .o_busy(o_busy), .o_done(o_done),
        .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_spi_clk(o_spi_clk),
        .o_spi_mosi(o_spi_mosi), .o_spi_cs_n(o_spi_cs_n), .i_spi_miso(i_spi_miso)
    );

    always #5 i_clk = ~i_clk;

    // SPI slave: capture MOSI on SCLK rise, present response bits on SCLK fall.
    logic [7:0] resp [0:15];
    logic [7:0] s_sh = 8'h00;
    int         s_bits = 0;
    int         s_idx = 0;
    logic [7:0] mosi_q [$];

    always @(posedge o_spi_clk) begin
        if (o_spi_cs_n === 1'b0) begin
            s_sh = {s_sh[6:0], o_spi_mosi};
            s_bits++;
            if (s_bits == 8) begin
                mosi_q.push_back(s_sh);
                s_bits = 0;
                s_idx++;
            end
        end
    end

    always @(negedge o_spi_clk) begin
        if (o_spi_cs_n === 1'b0 && s_idx < 16) i_spi_miso = resp[s_idx][7 - s_bits];
    end

    always @(posedge o_spi_cs_n) begin
        s_bits = 0;
        s_idx  = 0;
    end

    // Cycle-sampled monitor of handshakes and SCLK half-period lengths.
    int         dones = 0, pops = 0, rises = 0, cs_rises = 0, low_bad = 0, high_bad = 0, run = 0;
    logic       sclk_prev = 1'b1, cs_prev = 1'b1;
    logic [7:0] rd_q [$];

    always @(negedge i_clk) begin
        if (o_done === 1'b1) dones++;
        if (o_rd_valid === 1'b1) rd_q.push_back(o_rd_data);
        if (o_wr_ready === 1'b1 && i_wr_valid === 1'b1) pops++;
        if (o_spi_cs_n !== cs_prev) begin
            if (o_spi_cs_n === 1'b1) cs_rises++;
            cs_prev = o_spi_cs_n;
        end
        if (o_spi_clk === sclk_prev) begin
            run++;
        end else begin
            if (sclk_prev === 1'b0) begin
                rises++;
                if (run != TB_DIV) low_bad++;
            end else if (sclk_prev === 1'b1 && s_bits != 0 && run != TB_DIV) begin
                high_bad++;
            end
            sclk_prev = o_spi_clk;
            run = 1;
        end
    end

    logic [7:0] wr_bytes [0:3];

    task automatic start_frame(input logic wr, input logic [31:0] a, input logic [15:0] l);
        @(posedge i_clk); #1;
        i_write = wr; i_addr = a; i_len = l; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int c = 0; c < 4000 && dones == d0; c++) @(negedge i_clk);
        repeat (3) @(negedge i_clk);
    endtask

    task automatic feed(input int stall_len);
        int p0;
        for (int i = 0; i < 4; i++) begin
            i_wr_data  = wr_bytes[i];
            i_wr_valid = 1'b1;
            p0 = pops;
            for (int c = 0; c < 3000 && pops == p0; c++) @(negedge i_clk);
            @(posedge i_clk); #1;
            if (i == 0 && stall_len > 0) begin
                i_wr_valid = 1'b0;
                repeat (stall_len) @(posedge i_clk);
                #1;
            end
        end
        i_wr_valid = 1'b0;
    endtask

    task automatic clear_run();
        mosi_q.delete();
        rd_q.delete();
        for (int i = 0; i < 16; i++) resp[i] = 8'h00;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_start = 1'b0; i_write = 1'b0; i_addr = '0; i_len = '0;
        i_wr_data = '0; i_wr_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        vectors++;
        if ({o_busy, o_done, o_wr_ready, o_rd_valid, o_rd_data, o_spi_clk, o_spi_mosi, o_spi_cs_n} !== 15'b0000_00000000_101) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, want %b",
                {o_busy, o_done, o_wr_ready, o_rd_valid, o_rd_data, o_spi_clk, o_spi_mosi, o_spi_cs_n}, 15'b0000_00000000_101);
        end
        i_reset = 1'b0;
        repeat (2) @(posedge i_clk);
    endtask

    task automatic test_read();
        logic [7:0] exp [$];
        int d0, c0, r0;
        clear_run();
        resp[9] = 8'hCC; resp[10] = 8'hDD; resp[11] = 8'hEE; resp[12] = 8'hFF;
        d0 = dones; c0 = cs_rises; r0 = rises;
        start_frame(1'b0, 32'h11223344, 16'd4);
        wait_done(d0);
        exp = '{8'hA1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vectors++;
        if (mosi_q.size() != exp.size()) begin
            miscompares++;
            $display("FAIL read_frame_len: got %0d bytes, want %0d", mosi_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            vectors++;
            if (i >= mosi_q.size() || mosi_q[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL read_mosi[%0d]: got %h, want %h", i, (i < mosi_q.size()) ? mosi_q[i] : 8'hxx, exp[i]);
            end
        end
        exp = '{8'hCC, 8'hDD, 8'hEE, 8'hFF};
        vectors++;
        if (rd_q.size() != 4) begin
            miscompares++;
            $display("FAIL read_rd_valid_count: got %0d, want 4", rd_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= rd_q.size() || rd_q[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL read_rd_data[%0d]: got %h, want %h", i, (i < rd_q.size()) ? rd_q[i] : 8'hxx, exp[i]);
            end
        end
        vectors++;
        if (dones - d0 != 1) begin
            miscompares++;
            $display("FAIL read_done_count: got %0d, want 1", dones - d0);
        end
        vectors++;
        if (cs_rises - c0 != 1) begin
            miscompares++;
            $display("FAIL read_cs_continuous: got %0d cs_n rises, want 1", cs_rises - c0);
        end
        vectors++;
        if (rises - r0 != 104) begin
            miscompares++;
            $display("FAIL read_sclk_rises: got %0d, want 104", rises - r0);
        end
        vectors++;
        if (o_rd_data !== 8'hFF) begin
            miscompares++;
            $display("FAIL read_rd_data_held: got %h, want ff", o_rd_data);
        end
    endtask

    task automatic test_clk_timing();
        int d0, r0;
        clear_run();
        d0 = dones; r0 = rises;
        @(posedge i_clk); #1;
        i_write = 1'b0; i_addr = 32'hA5A50001; i_len = 16'd2; i_start = 1'b1;
        vectors++;
        if (o_spi_cs_n !== 1'b1 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_pre: got cs_n=%b busy=%b, want cs_n=1 busy=0", o_spi_cs_n, o_busy);
        end
        @(posedge i_clk); #1;
        i_start = 1'b0;
        vectors++;
        if ({o_spi_cs_n, o_busy, o_spi_mosi, o_spi_clk} !== 4'b0111) begin
            miscompares++;
            $display("FAIL start_latency: got cs_n/busy/mosi/sclk=%b, want 0111", {o_spi_cs_n, o_busy, o_spi_mosi, o_spi_clk});
        end
        wait_done(d0);
        vectors++;
        if (rises - r0 != 88) begin
            miscompares++;
            $display("FAIL timing_rises: got %0d, want 88 (11 bytes x 8)", rises - r0);
        end
        vectors++;
        if (low_bad != 0 || high_bad != 0) begin
            miscompares++;
            $display("FAIL timing_half_period: got %0d bad lows, %0d bad highs, want 0", low_bad, high_bad);
        end
    endtask

    task automatic run_write(input int stall, input string tag);
        logic [7:0] exp [$];
        int d0, p0, r_snap, stall_bad;
        logic mosi_snap;
        clear_run();
        wr_bytes[0] = 8'h55; wr_bytes[1] = 8'h66; wr_bytes[2] = 8'h77; wr_bytes[3] = 8'h88;
        d0 = dones; p0 = pops; stall_bad = 0;
        fork
            begin
                start_frame(1'b1, 32'h11223344, 16'd4);
                wait_done(d0);
            end
            feed(stall);
            if (stall > 0) begin
                for (int c = 0; c < 3000 && pops - p0 < 1; c++) @(negedge i_clk);
                repeat (70) @(negedge i_clk);
                r_snap = rises; mosi_snap = o_spi_mosi;
                repeat (10) begin
                    @(negedge i_clk);
                    if (o_spi_clk !== 1'b1 || o_spi_cs_n !== 1'b0 || o_spi_mosi !== mosi_snap) stall_bad++;
                end
                vectors++;
                if (stall_bad != 0 || rises != r_snap) begin
                    miscompares++;
                    $display("FAIL %s_stall_idle: got %0d bad cycles, %0d edges, want 0", tag, stall_bad, rises - r_snap);
                end
            end
        join
        exp = '{8'hA2, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h04, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 8'h00};
        vectors++;
        if (mosi_q.size() != exp.size()) begin
            miscompares++;
            $display("FAIL %s_frame_len: got %0d bytes, want %0d", tag, mosi_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            vectors++;
            if (i >= mosi_q.size() || mosi_q[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL %s_mosi[%0d]: got %h, want %h", tag, i, (i < mosi_q.size()) ? mosi_q[i] : 8'hxx, exp[i]);
            end
        end
        vectors++;
        if (pops - p0 != 4 || rd_q.size() != 0 || dones - d0 != 1) begin
            miscompares++;
            $display("FAIL %s_handshake: got pops=%0d rd_valid=%0d done=%0d, want 4 0 1", tag, pops - p0, rd_q.size(), dones - d0);
        end
    endtask

    task automatic test_write();
        run_write(0, "write");
    endtask

    task automatic test_underrun();
        run_write(84, "underrun");
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [$];
        int d0;
        clear_run();
        d0 = dones;
        start_frame(1'b0, 32'h11223344, 16'd4);
        for (int c = 0; c < 2000 && mosi_q.size() < 3; c++) @(negedge i_clk);
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        vectors++;
        if ({o_busy, o_done, o_wr_ready, o_rd_valid, o_rd_data, o_spi_clk, o_spi_mosi, o_spi_cs_n} !== 15'b0000_00000000_101) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %b, want %b",
                {o_busy, o_done, o_wr_ready, o_rd_valid, o_rd_data, o_spi_clk, o_spi_mosi, o_spi_cs_n}, 15'b0000_00000000_101);
        end
        i_reset = 1'b0;
        repeat (50) @(negedge i_clk);
        vectors++;
        if (dones != d0 || mosi_q.size() != 3) begin
            miscompares++;
            $display("FAIL reset_mid_abandon: got done=%0d bytes=%0d, want 0 3", dones - d0, mosi_q.size());
        end
        clear_run();
        resp[9] = 8'h5A;
        d0 = dones;
        start_frame(1'b0, 32'h0000_0100, 16'd1);
        wait_done(d0);
        exp = '{8'hA1, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        vectors++;
        if (mosi_q.size() != exp.size()) begin
            miscompares++;
            $display("FAIL after_reset_len: got %0d bytes, want %0d", mosi_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            vectors++;
            if (i >= mosi_q.size() || mosi_q[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL after_reset_mosi[%0d]: got %h, want %h", i, (i < mosi_q.size()) ? mosi_q[i] : 8'hxx, exp[i]);
            end
        end
        vectors++;
        if (rd_q.size() != 1 || (rd_q.size() == 1 && rd_q[0] !== 8'h5A)) begin
            miscompares++;
            $display("FAIL after_reset_rd: got %0d bytes first=%h, want 1 byte 5a", rd_q.size(), o_rd_data);
        end
    endtask

    task automatic test_len0();
        logic [7:0] exp [$];
        int d0;
        clear_run();
        d0 = dones;
        start_frame(1'b0, 32'hDEADBEEF, 16'd0);
        repeat (100) @(posedge i_clk);
        #1;
        i_write = 1'b1; i_addr = 32'h0; i_len = 16'd3; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_done(d0);
        repeat (100) @(negedge i_clk);
        exp = '{8'hA1, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00};
        vectors++;
        if (mosi_q.size() != exp.size()) begin
            miscompares++;
            $display("FAIL len0_frame_len: got %0d bytes, want %0d", mosi_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            vectors++;
            if (i >= mosi_q.size() || mosi_q[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL len0_mosi[%0d]: got %h, want %h", i, (i < mosi_q.size()) ? mosi_q[i] : 8'hxx, exp[i]);
            end
        end
        vectors++;
        if (rd_q.size() != 0 || dones - d0 != 1 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_status: got rd_valid=%0d done=%0d busy=%b, want 0 1 0", rd_q.size(), dones - d0, o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_clk_timing();
        test_write();
        test_underrun();
        test_reset_mid();
        test_len0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
